ram_serial_loader: RTL and testbench

RAM_SERIAL_LOADER -- requirements
Module: ram_serial_loader

---
 rtl/ram_serial_loader.sv | 144 ++++++++++++++
 tb/tb_ram_serial_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_serial_loader.sv
// Serial byte loader for a 16K x 16 RAM: assembles big-endian byte pairs into
// words, writes them from address 0 upward, and hands the RAM back to the CPU
// port whenever no load is running.
// Optional feature: define RAM_LOADER_CLEAR_EN to zero the whole RAM before
// the bytes are loaded.
module ram_serial_loader #(
  parameter int unsigned DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [15:0] cpu_in,
  input  logic [14:0] cpu_address,
  input  logic        cpu_load,
  output logic [15:0] ram_in,
  output logic [14:0] ram_address,
  output logic        ram_load,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = 15;
  localparam int unsigned PW = 14;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
`ifdef RAM_LOADER_CLEAR_EN
    CLEAR = 3'd5,
`endif
    DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   word_q, word_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic [CW-1:0]   count_clamp;
  logic            ld_load;
  logic [DW-1:0]   ld_data;
  logic [CW-1:0]   ld_addr;

  // Requested length limited to the RAM depth
  assign count_clamp = (word_count > CW'(DEPTH)) ? CW'(DEPTH) : word_count;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state, byte assembly and loader-side RAM request
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    count_d    = count_q;
    done_d     = done_q;
    byte_ready = 1'b0;
    ld_load    = 1'b0;
    ld_data    = word_q;
    ld_addr    = {1'b0, ptr_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = count_clamp;
          done_d  = 1'b0;
          ptr_d   = '0;
`ifdef RAM_LOADER_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = (count_clamp == '0) ? DONE : HI;
`endif
        end
      end
`ifdef RAM_LOADER_CLEAR_EN
      CLEAR: begin
        ld_load = 1'b1;
        ld_data = '0;
        if (ptr_q == PW'(DEPTH - 1)) begin
          ptr_d   = '0;
          state_d = (count_q == '0) ? DONE : HI;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
`endif
      HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d[15:8] = byte_in;
          state_d      = LO;
        end
      end
      LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d[7:0] = byte_in;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        ld_load = 1'b1;
        ptr_d   = ptr_q + PW'(1);
        state_d = ({1'b0, ptr_q} == (count_q - CW'(1))) ? DONE : HI;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port mux: loader owns the RAM while busy, CPU otherwise
  always_comb begin
    busy        = (state_q != IDLE) && (state_q != DONE);
    ram_in      = busy ? ld_data : cpu_in;
    ram_address = busy ? ld_addr : cpu_address;
    ram_load    = busy ? ld_load : cpu_load;
  end

  assign done = done_q;

endmodule

// File: tb/tb_ram_serial_loader.sv
// Directed self-checking bench for ram_serial_loader with a behavioural RAM16K.
// Build with +define+RAM_LOADER_CLEAR_EN to exercise the clear-before-load mode.
`timescale 1ns/1ps
module tb_ram_serial_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] cpu_in;
  logic [14:0] cpu_address;
  logic        cpu_load;
  logic [15:0] ram_in;
  logic [14:0] ram_address;
  logic        ram_load;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural RAM and free-running activity counters
  logic [15:0] mem [0:16383];
  logic        fill_req = 1'b0;
  logic [15:0] fill_val = 16'h0000;
  int busy_total = 0;
  int load_total = 0;
  int ldr_total  = 0;
  int bad_addr   = 0;

  always #5 clk = ~clk;

  ram_serial_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .word_count  (word_count),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .cpu_in      (cpu_in),
    .cpu_address (cpu_address),
    .cpu_load    (cpu_load),
    .ram_in      (ram_in),
    .ram_address (ram_address),
    .ram_load    (ram_load),
    .busy        (busy),
    .done        (done)
  );

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 16384; i++) mem[i] <= fill_val;
    end else if (ram_load) begin
      mem[ram_address[13:0]] <= ram_in;
    end
    if (busy) busy_total <= busy_total + 1;
    if (ram_load) load_total <= load_total + 1;
    if (busy && ram_load) ldr_total <= ldr_total + 1;
    if (busy && ram_address[14]) bad_addr <= bad_addr + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [14:0] cnt);
    start = 1'b1;
    word_count = cnt;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      byte_valid = 1'b0;
      step();
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20000) begin
      step();
      n++;
    end
    if (!byte_ready) check_val("byte_ready_timeout", 32'(byte_ready), 32'd1);
    step();
  endtask

  task automatic wait_done();
    int n;
    byte_valid = 1'b0;
    n = 0;
    while (!(done && !busy) && n < 20000) begin
      step();
      n++;
    end
    if (!(done && !busy)) check_val("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
    cpu_address = a;
    cpu_in = d;
    cpu_load = 1'b1;
    step();
    cpu_load = 1'b0;
  endtask

  initial begin
    int b0, l0, w0;
    reset = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    cpu_in = '0; cpu_address = '0; cpu_load = 1'b0;
    fill_req = 1'b1; fill_val = 16'h0000;
    step();
    fill_req = 1'b0;
    // Start and valid bytes during reset must be overridden
    start = 1'b1; word_count = 15'd2; byte_valid = 1'b1;
    step();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_byte_ready", 32'(byte_ready), 32'd0);
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
    step();
    check_val("rst_idle_busy", 32'(busy), 32'd0);

    // Idle pass-through is combinational
    cpu_in = 16'hBEEF; cpu_address = 15'h1234; cpu_load = 1'b1;
    #1;
    check_val("pt_in", 32'(ram_in), 32'h0000BEEF);
    check_val("pt_addr", 32'(ram_address), 32'h1234);
    check_val("pt_load", 32'(ram_load), 32'd1);
    cpu_load = 1'b0;
    step();

`ifdef RAM_LOADER_CLEAR_EN
    fill_req = 1'b1; fill_val = 16'hFFFF;
    step();
    fill_req = 1'b0;
    b0 = busy_total;
    start_load(15'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h07, 1'b0);
    wait_done();
    check_val("clr_ram0", 32'(mem[0]), 32'h0007);
    check_val("clr_ram100", 32'(mem[100]), 32'h0000);
    check_val("clr_ram16383", 32'(mem[16383]), 32'h0000);
    check_val("clr_busy_cycles", 32'(busy_total - b0), 32'(16384 + 3));
    check_val("clr_done", 32'(done), 32'd1);
`else
    // Two words with valid held high
    b0 = busy_total; w0 = ldr_total;
    start_load(15'd2);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    wait_done();
    check_val("w2_ram0", 32'(mem[0]), 32'h1234);
    check_val("w2_ram1", 32'(mem[1]), 32'hABCD);
    check_val("w2_done", 32'(done), 32'd1);
    check_val("w2_busy_cycles", 32'(busy_total - b0), 32'd6);
    check_val("w2_writes", 32'(ldr_total - w0), 32'd2);

    // Zero-length load
    b0 = busy_total; l0 = load_total;
    start_load(15'd0);
    check_val("z_done_cleared", 32'(done), 32'd0);
    wait_done();
    repeat (2) step();
    check_val("z_done", 32'(done), 32'd1);
    check_val("z_no_load", 32'(load_total - l0), 32'd0);
    check_val("z_no_busy", 32'(busy_total - b0), 32'd0);

    // Three words with toggling valid, blocked CPU writes, ignored restart
    w0 = ldr_total;
    start_load(15'd3);
    check_val("t3_done_cleared", 32'(done), 32'd0);
    cpu_address = 15'd10; cpu_in = 16'hDEAD; cpu_load = 1'b1;
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    start = 1'b1; word_count = 15'd1;
    step();
    start = 1'b0; word_count = 15'd3;
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    send_byte(8'hE5, 1'b1);
    send_byte(8'hF6, 1'b1);
    cpu_load = 1'b0;
    wait_done();
    check_val("t3_ram0", 32'(mem[0]), 32'hA1B2);
    check_val("t3_ram1", 32'(mem[1]), 32'hC3D4);
    check_val("t3_ram2", 32'(mem[2]), 32'hE5F6);
    check_val("t3_cpu_blocked", 32'(mem[10]), 32'h0000);
    check_val("t3_writes", 32'(ldr_total - w0), 32'd3);
    check_val("t3_idle_ready", 32'(byte_ready), 32'd0);

    // Reset after the third byte of a four-word load
    cpu_write(15'd1, 16'h7777);
    start_load(15'd4);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    byte_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("ab_busy", 32'(busy), 32'd0);
    check_val("ab_done", 32'(done), 32'd0);
    check_val("ab_byte_ready", 32'(byte_ready), 32'd0);
    cpu_write(15'd5, 16'h5A5A);
    step();
    check_val("ab_ram0", 32'(mem[0]), 32'h1122);
    check_val("ab_ram1", 32'(mem[1]), 32'h7777);
    check_val("ab_cpu_write", 32'(mem[5]), 32'h5A5A);
`endif

    check_val("addr_msb_zero", 32'(bad_addr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
